bullet_ctrl: RTL and testbench

Player projectile manager for the invaders game. Spawns bullets above the player paddle on fire requests. Advances them upward once per frame, retires them at the screen top, and detects hits against the ball/object box. Sits between the paddle controller and input logic upstream, and the pixel compositor and score logic downstream. It answers per-pixel "bullet here?" queries with 1-cycle latency.

---
 rtl/bullet_ctrl_pkg.sv | 26 ++
 rtl/bullet_ctrl_if.sv | 24 ++
 rtl/bullet_ctrl_slot.sv | 49 ++++
 rtl/bullet_ctrl.sv | 78 +++++++
 tb/tb_bullet_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/bullet_ctrl_pkg.sv
// bullet_ctrl_pkg: bullet pool constants, slot record and box-overlap helper
package bullet_ctrl_pkg;
    localparam int VRES            = 720;
    localparam int PADDLE_W        = 50;
    localparam int PADDLE_H        = 20;
    localparam int OBJ_SIZE        = 50;
    localparam int MAX_BULLETS     = 4;
    localparam int BULLET_W        = 4;
    localparam int BULLET_H        = 16;
    localparam int BULLET_SPEED    = 16;
    localparam int COOLDOWN_FRAMES = 8;
    localparam logic [23:0] BULLET_COLOR = 24'hFFFFFF;
    localparam int BULLET_SPAWN_Y  = VRES - PADDLE_H - BULLET_H;

    typedef struct packed {
        logic        active;
        logic [10:0] x;
        logic [9:0]  y;
    } bullet_t;

    // Strict 1-D overlap of [a, a+a_len) and [b, b+b_len); 12-bit sums never wrap.
    function automatic logic spans(input logic [11:0] a, input logic [11:0] a_len,
                                   input logic [11:0] b, input logic [11:0] b_len);
        return (a < b + b_len) && (b < a + a_len);
    endfunction
endpackage

// File: rtl/bullet_ctrl_if.sv
// bullet_ctrl_if: game-side inputs and compositor/score outputs of the bullet pool
interface bullet_ctrl_if;
    logic        frame_tick;
    logic        fire;
    logic        game_over;
    logic [10:0] paddle_x;
    logic [10:0] obj_x;
    logic [9:0]  obj_y;
    logic [10:0] px_x;
    logic [9:0]  px_y;
    logic        bullet_on;
    logic [23:0] bullet_rgb;
    logic        hit;
    logic [3:0]  active_cnt;

    modport master (
        output frame_tick, fire, game_over, paddle_x, obj_x, obj_y, px_x, px_y,
        input  bullet_on, bullet_rgb, hit, active_cnt
    );
    modport slave (
        input  frame_tick, fire, game_over, paddle_x, obj_x, obj_y, px_x, px_y,
        output bullet_on, bullet_rgb, hit, active_cnt
    );
endinterface

// File: rtl/bullet_ctrl_slot.sv
// bullet_ctrl_slot: one bullet register with hit/retire/move/spawn update and pixel cover
module bullet_ctrl_slot
    import bullet_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_i,
    input  logic        clear_i,
    input  logic        spawn_i,
    input  logic [10:0] spawn_x_i,
    input  logic [10:0] obj_x_i,
    input  logic [9:0]  obj_y_i,
    input  logic [10:0] px_x_i,
    input  logic [9:0]  px_y_i,
    output logic        active_o,
    output logic        active_d_o,
    output logic        hit_o,
    output logic        cover_o
);
    bullet_t slot_q, slot_d;
    logic    retire;

    always_comb begin
        hit_o   = slot_q.active
                  && spans({1'b0, slot_q.x}, 12'(BULLET_W), {1'b0, obj_x_i}, 12'(OBJ_SIZE))
                  && spans({2'b0, slot_q.y}, 12'(BULLET_H), {2'b0, obj_y_i}, 12'(OBJ_SIZE));
        retire  = slot_q.active && slot_q.y < 10'(BULLET_SPEED);
        cover_o = slot_q.active
                  && spans({1'b0, slot_q.x}, 12'(BULLET_W), {1'b0, px_x_i}, 12'd1)
                  && spans({2'b0, slot_q.y}, 12'(BULLET_H), {2'b0, px_y_i}, 12'd1);
        slot_d  = slot_q;
        if (clear_i)
            slot_d.active = 1'b0;
        else if (tick_i && (hit_o || retire))
            slot_d.active = 1'b0;
        else if (tick_i && slot_q.active)
            slot_d.y = slot_q.y - 10'(BULLET_SPEED);
        else if (tick_i && spawn_i)
            slot_d = '{active: 1'b1, x: spawn_x_i, y: 10'(BULLET_SPAWN_Y)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) slot_q <= '0;
        else        slot_q <= slot_d;
    end

    assign active_o   = slot_q.active;
    assign active_d_o = slot_d.active;
endmodule

// File: rtl/bullet_ctrl.sv
// bullet_ctrl: player bullet pool with fire cooldown, object hits and pixel query
module bullet_ctrl
    import bullet_ctrl_pkg::*;
#(
    parameter int COOLDOWN = COOLDOWN_FRAMES
) (
    input  logic         clk,
    input  logic         rst_n,
    bullet_ctrl_if.slave bus
);
    logic                   fire_latch_q, fire_latch_d, hit_q, hit_d, on_q, on_d, spawn_ok;
    logic [3:0]             cooldown_q, cooldown_d, cnt_q, cnt_d;
    logic [23:0]            rgb_q, rgb_d;
    logic [10:0]            spawn_x;
    logic [MAX_BULLETS-1:0] act_q, act_d, free, spawn, hits, covers;

    assign free    = ~act_q;
    assign spawn_x = bus.paddle_x + 11'(PADDLE_W / 2 - BULLET_W / 2);

    for (genvar g = 0; g < MAX_BULLETS; g++) begin : g_slot
        bullet_ctrl_slot u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick_i     (bus.frame_tick),
            .clear_i    (bus.game_over),
            .spawn_i    (spawn[g]),
            .spawn_x_i  (spawn_x),
            .obj_x_i    (bus.obj_x),
            .obj_y_i    (bus.obj_y),
            .px_x_i     (bus.px_x),
            .px_y_i     (bus.px_y),
            .active_o   (act_q[g]),
            .active_d_o (act_d[g]),
            .hit_o      (hits[g]),
            .cover_o    (covers[g])
        );
    end

    always_comb begin
        spawn_ok     = bus.frame_tick && (fire_latch_q || bus.fire) && cooldown_q == 4'd0
                       && !bus.game_over && |free;
        // two's-complement trick isolates the lowest free slot
        spawn        = spawn_ok ? free & (~free + MAX_BULLETS'(1)) : '0;
        fire_latch_d = !bus.frame_tick && (fire_latch_q || bus.fire);
        cooldown_d   = bus.game_over   ? 4'd0 :
                       !bus.frame_tick ? cooldown_q :
                       spawn_ok        ? 4'(COOLDOWN) :
                                         cooldown_q - {3'b0, cooldown_q != 4'd0};
        hit_d        = bus.frame_tick && !bus.game_over && |hits;
        on_d         = |covers;
        rgb_d        = on_d ? BULLET_COLOR : 24'h0;
        cnt_d        = '0;
        for (int i = 0; i < MAX_BULLETS; i++) cnt_d = cnt_d + 4'(act_d[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_latch_q <= 1'b0;
            cooldown_q   <= '0;
            hit_q        <= 1'b0;
            on_q         <= 1'b0;
            rgb_q        <= '0;
            cnt_q        <= '0;
        end else begin
            fire_latch_q <= fire_latch_d;
            cooldown_q   <= cooldown_d;
            hit_q        <= hit_d;
            on_q         <= on_d;
            rgb_q        <= rgb_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.bullet_on  = on_q;
    assign bus.bullet_rgb = rgb_q;
    assign bus.hit        = hit_q;
    assign bus.active_cnt = cnt_q;
endmodule

// File: tb/tb_bullet_ctrl.sv
// tb_bullet_ctrl: directed scenarios against a behavioural bullet-pool model
module tb_bullet_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bullet_ctrl_if bus ();
    bullet_ctrl_if fast ();
    assign fast.frame_tick = bus.frame_tick;
    assign fast.fire       = bus.fire;
    assign fast.game_over  = bus.game_over;
    assign fast.paddle_x   = bus.paddle_x;
    assign fast.obj_x      = bus.obj_x;
    assign fast.obj_y      = bus.obj_y;
    assign fast.px_x       = bus.px_x;
    assign fast.px_y       = bus.px_y;

    bullet_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    // zero cooldown lets consecutive bullets share the object box on one tick
    bullet_ctrl #(.COOLDOWN(0)) dut_fast (.clk(clk), .rst_n(rst_n), .bus(fast));

    int errors = 0, checks = 0;
    bit run = 0;
    int m_act[4], m_x[4], m_y[4];
    int m_cd, m_free, e_cnt;
    bit m_latch, m_on, m_any, e_hit, e_on;
    int at_k[8]  = '{0, 8, 9, 18, 27, 36, 43, 44};
    int exp_c[8] = '{1, 1, 2, 3, 4, 4, 3, 4};

    function automatic bit boxes(int a, int alen, int b, int blen);
        return a < b + blen && b < a + alen;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_act[i]) m_act[i] = 0;
            m_cd = 0; m_latch = 0; e_hit = 0; e_on = 0; e_cnt = 0;
        end else begin
            m_on = 0; m_any = 0; m_free = -1;
            foreach (m_act[i]) begin
                if (m_act[i] && boxes(m_x[i], 4, int'(bus.px_x), 1) && boxes(m_y[i], 16, int'(bus.px_y), 1))
                    m_on = 1;
                if (!m_act[i] && m_free < 0) m_free = i;
            end
            if (bus.game_over) begin
                foreach (m_act[i]) m_act[i] = 0;
                m_cd = 0;
            end else if (bus.frame_tick) begin
                foreach (m_act[i]) if (m_act[i]) begin
                    if (boxes(m_x[i], 4, int'(bus.obj_x), 50) && boxes(m_y[i], 16, int'(bus.obj_y), 50)) begin
                        m_act[i] = 0; m_any = 1;
                    end else if (m_y[i] < 16) m_act[i] = 0;
                    else m_y[i] -= 16;
                end
                if ((m_latch || bus.fire) && m_cd == 0 && m_free >= 0) begin
                    m_act[m_free] = 1; m_x[m_free] = int'(bus.paddle_x) + 50 / 2 - 4 / 2;
                    m_y[m_free] = 720 - 20 - 16; m_cd = 8;
                end else if (m_cd > 0) m_cd--;
            end
            e_hit = m_any;
            m_latch = !bus.frame_tick && (m_latch || bus.fire);
            e_cnt = 0;
            foreach (m_act[i]) e_cnt += m_act[i];
            e_on = m_on;
        end
    end

    always @(negedge clk) if (run) begin
        chk("hit", 32'(bus.hit), 32'(e_hit));
        chk("bullet_on", 32'(bus.bullet_on), 32'(e_on));
        chk("bullet_rgb", 32'(bus.bullet_rgb), e_on ? 32'hFFFFFF : 32'h0);
        chk("active_cnt", 32'(bus.active_cnt), 32'(e_cnt));
    end

    task automatic cyc(); @(negedge clk); #2; endtask
    task automatic tick(); bus.frame_tick = 1; cyc(); bus.frame_tick = 0; endtask
    task automatic ticks(input int n); repeat (n) begin tick(); cyc(); end endtask
    task automatic px(input int x, input int y); bus.px_x = 11'(x); bus.px_y = 10'(y); cyc(); endtask
    task automatic do_reset();
        rst_n = 0; bus.frame_tick = 0; bus.fire = 0; bus.game_over = 0;
        bus.paddle_x = 11'd600; bus.obj_x = 0; bus.obj_y = 0; bus.px_x = 0; bus.px_y = 0;
        cyc(); cyc(); rst_n = 1; cyc();
    endtask

    initial begin
        do_reset();
        run = 1;
        chk("rst_cnt", 32'(bus.active_cnt), 0);
        chk("rst_on", 32'(bus.bullet_on), 0);
        chk("rst_rgb", 32'(bus.bullet_rgb), 0);
        chk("rst_hit", 32'(bus.hit), 0);
        // spawn, query and fly to the top
        bus.fire = 1; cyc(); bus.fire = 0; tick();
        chk("spawn_cnt", 32'(bus.active_cnt), 1);
        px(623, 684); chk("q_origin", 32'(bus.bullet_on), 1);
        chk("q_rgb", 32'(bus.bullet_rgb), 32'hFFFFFF);
        px(627, 684); chk("q_right_edge", 32'(bus.bullet_on), 0);
        px(626, 699); chk("q_far_corner", 32'(bus.bullet_on), 1);
        tick();
        px(623, 684); chk("q_moved_old", 32'(bus.bullet_on), 0);
        px(623, 683); chk("q_moved_new", 32'(bus.bullet_on), 1);
        ticks(41);
        px(623, 12); chk("q_y12", 32'(bus.bullet_on), 1);
        px(623, 11); chk("q_y11", 32'(bus.bullet_on), 0);
        tick();
        chk("retire_cnt", 32'(bus.active_cnt), 0);
        chk("retire_nohit", 32'(bus.hit), 0);
        // held fire: cooldown spacing and full pool
        do_reset(); bus.fire = 1;
        for (int k = 0; k < 45; k++) begin
            tick();
            foreach (at_k[j]) if (at_k[j] == k) chk($sformatf("hold_cnt_t%0d", k), 32'(bus.active_cnt), 32'(exp_c[j]));
            cyc();
        end
        bus.fire = 0;
        // single hit
        do_reset(); bus.obj_x = 11'd600; bus.obj_y = 10'd600;
        bus.fire = 1; cyc(); bus.fire = 0; ticks(1); ticks(3);
        px(623, 636); chk("q_y636", 32'(bus.bullet_on), 1);
        chk("prehit_cnt", 32'(bus.active_cnt), 1);
        tick();
        chk("hit_pulse", 32'(bus.hit), 1);
        chk("hit_cnt", 32'(bus.active_cnt), 0);
        cyc(); chk("hit_once", 32'(bus.hit), 0);
        // double hit on the zero-cooldown pool
        do_reset();
        bus.fire = 1; tick(); tick(); bus.fire = 0;
        chk("fast_two", 32'(fast.active_cnt), 2);
        ticks(3);
        chk("fast_prehit", 32'(fast.hit), 0);
        bus.obj_x = 11'd600; bus.obj_y = 10'd600; cyc();
        chk("fast_before", 32'(fast.active_cnt), 2);
        tick();
        chk("fast_hit", 32'(fast.hit), 1);
        chk("fast_cnt", 32'(fast.active_cnt), 0);
        cyc(); chk("fast_hit_once", 32'(fast.hit), 0);
        // game over and asynchronous reset
        do_reset(); bus.fire = 1;
        for (int k = 0; k < 19; k++) ticks(1);
        bus.fire = 0;
        chk("go_three", 32'(bus.active_cnt), 3);
        bus.game_over = 1; bus.fire = 1; cyc();
        chk("go_clear", 32'(bus.active_cnt), 0);
        tick();
        chk("go_tick_cnt", 32'(bus.active_cnt), 0);
        chk("go_tick_hit", 32'(bus.hit), 0);
        bus.game_over = 0; bus.fire = 0; tick();
        chk("go_latch_gone", 32'(bus.active_cnt), 0);
        bus.fire = 1; cyc(); bus.fire = 0; tick();
        chk("go_cd_clear", 32'(bus.active_cnt), 1);
        px(623, 684); chk("pre_rst_on", 32'(bus.bullet_on), 1);
        rst_n = 0; #1;
        chk("arst_on", 32'(bus.bullet_on), 0);
        chk("arst_rgb", 32'(bus.bullet_rgb), 0);
        chk("arst_cnt", 32'(bus.active_cnt), 0);
        chk("arst_hit", 32'(bus.hit), 0);
        cyc(); rst_n = 1; cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
